sync_fifo_param: RTL

Parametrised single-clock FIFO and the successor to the fixed 8x8 synchronous FIFO.
- Generalises data width and depth, and adds occupancy output, programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags and a registered read-valid strobe.
- Count tracks only accepted operations, so simultaneous read and write are exact.
- Sits between producer and consumer datapaths in the same clock domain.

---
 rtl/sync_fifo_pkg.sv | 14 +
 rtl/sync_fifo_mem.sv | 21 ++
 rtl/sync_fifo_param.sv | 88 ++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared constants, clog2 and parameter legality check for sync_fifo_param
package sync_fifo_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 8;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic bit fifo_params_ok(input int depth, input int ae, input int af);
    return depth >= 2 && (depth & (depth - 1)) == 0 && ae < af && af <= depth;
  endfunction
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: DEPTH x DATA_W storage, one synchronous write port, one asynchronous read port
//   clk          write clock
//   we/waddr/wdata  write enable, address, data
//   raddr/rdata  combinational read address and data
module sync_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int ADDR_W = sync_fifo_pkg::clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (we) r_mem[waddr] <= wdata;
  assign rdata = r_mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy, thresholds and sticky errors
//   clk, reset (sync, active-high); write_en/data_in push; read_en pop
//   out/out_valid read data and strobe; full/empty/almost_full/almost_empty decoded from count
//   count occupancy 0..DEPTH; overflow/underflow sticky until reset
//   SYNC_FIFO_FWFT_EN: first-word-fall-through (out = head, out_valid = !empty)
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  localparam int ADDR_W = clog2(DEPTH),
  localparam int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_en,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);
  if (!fifo_params_ok(DEPTH, AE_THRESH, AF_THRESH)) begin : g_param_err
    $error("sync_fifo_param: illegal DEPTH/AE_THRESH/AF_THRESH");
  end
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf, r_unf;
  logic              w_wr_acc, w_rd_acc;
  logic [DATA_W-1:0] w_rdata;
  assign full         = r_count == CNT_W'(DEPTH);
  assign empty        = r_count == '0;
  assign almost_full  = r_count >= CNT_W'(AF_THRESH);
  assign almost_empty = r_count <= CNT_W'(AE_THRESH);
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;
  assign w_wr_acc     = write_en & ~full;
  assign w_rd_acc     = read_en & ~empty;
  sync_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (w_wr_acc),
    .waddr (r_wr_ptr),
    .wdata (data_in),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );
  always_ff @(posedge clk)
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_acc ? r_wr_ptr + ADDR_W'(1) : r_wr_ptr;
      r_rd_ptr <= w_rd_acc ? r_rd_ptr + ADDR_W'(1) : r_rd_ptr;
      r_count  <= (w_wr_acc == w_rd_acc) ? r_count :
                  w_wr_acc ? r_count + CNT_W'(1) : r_count - CNT_W'(1);
      r_ovf    <= r_ovf | (write_en & full);
      r_unf    <= r_unf | (read_en & empty);
    end
`ifdef SYNC_FIFO_FWFT_EN
  assign out       = w_rdata;
  assign out_valid = ~empty;
`else
  logic [DATA_W-1:0] r_out;
  logic              r_out_valid;
  always_ff @(posedge clk)
    if (reset) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out       <= w_rd_acc ? w_rdata : r_out;
      r_out_valid <= w_rd_acc;
    end
  assign out       = r_out;
  assign out_valid = r_out_valid;
`endif
endmodule
